// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared constants for the iterative shift-and-add multiplier:
//                FSM state encoding and the step-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    // FSM state encoding (2-bit)
    localparam int         STATE_W = 2;
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CALC    = 2'd1;
    localparam logic [1:0] FIX     = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Step counter width: $clog2(width), never below one bit
    function automatic int cntWidth(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : Ripple-carry adder, o_sum = i_a + i_b + i_cin (mod 2^N).
//                o_overflow is the two's-complement overflow flag.
//  Ports       : i_a, i_b   [ADDER_SIZE]  operands
//                i_cin      [1]           carry in
//                o_sum      [ADDER_SIZE]  sum
//                o_overflow [1]           signed overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module adder #(
    parameter int ADDER_SIZE = 32
) (
    input  logic [ADDER_SIZE-1:0] i_a,
    input  logic [ADDER_SIZE-1:0] i_b,
    input  logic                  i_cin,
    output logic [ADDER_SIZE-1:0] o_sum,
    output logic                  o_overflow
);

    logic [ADDER_SIZE:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar i = 0; i < ADDER_SIZE; i++) begin : g_ripple
            assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
            assign w_carry[i+1]   = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
    endgenerate

    assign o_overflow = w_carry[ADDER_SIZE] ^ w_carry[ADDER_SIZE-1];

endmodule
`default_nettype wire

// File: rtl/twos_negate.sv
`default_nettype none
// ============================================================================
//  Module      : twos_negate
//  Description : Two's-complement negate, o_negX = ~i_x + 1, built on adder.
//  Ports       : i_x    [WIDTH]  value
//                o_negX [WIDTH]  negated value
//  Revision    : 1.0 - initial release
// ============================================================================
module twos_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_negX
);

    logic w_unusedOvf;

    adder #(.ADDER_SIZE(WIDTH)) u_adder (
        .i_a        (~i_x),
        .i_b        ('0),
        .i_cin      (1'b1),
        .o_sum      (o_negX),
        .o_overflow (w_unusedOvf)
    );

endmodule
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Iterative shift-and-add multiplier (RV32M MUL/MULH/MULHSU/
//                MULHU). Multiplies operand magnitudes over WIDTH cycles, then
//                applies the sign to the full 2*WIDTH-bit product.
//  Ports       : clk      [1]        rising-edge clock
//                rstN     [1]        asynchronous active-low reset
//                start    [1]        request, accepted when not busy
//                aSigned  [1]        dIn0 is two's complement
//                bSigned  [1]        dIn1 is two's complement
//                dIn0     [WIDTH]    multiplicand
//                dIn1     [WIDTH]    multiplier
//                busy     [1]        operation in progress
//                done     [1]        one-cycle product-valid pulse
//                dOut     [2*WIDTH]  product, held until next accepted start
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               start,
    input  logic               aSigned,
    input  logic               bSigned,
    input  logic [WIDTH-1:0]   dIn0,
    input  logic [WIDTH-1:0]   dIn1,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] dOut
);

    localparam int               CNT_W      = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_nextState;

    logic [WIDTH-1:0]   r_magA;
    logic [WIDTH:0]     r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_dOut;

    logic               w_accept;
    logic               w_negateA;
    logic               w_negateB;
    logic [WIDTH-1:0]   w_negIn0;
    logic [WIDTH-1:0]   w_negIn1;
    logic [WIDTH-1:0]   w_magIn0;
    logic [WIDTH-1:0]   w_magIn1;
    logic [WIDTH:0]     w_addend;
    logic [WIDTH:0]     w_sum;
    logic [CNT_W-1:0]   w_cntInc;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_negProduct;
    logic               w_unusedAccOvf;
    logic               w_unusedCntOvf;

    // A start is taken in IDLE and also in DONE, which allows back-to-back ops
    assign w_accept  = start & ((r_state == IDLE) | (r_state == DONE));

    // Operand magnitudes; the signed minimum maps onto itself, which is the
    // correct unsigned magnitude
    assign w_negateA = aSigned & dIn0[WIDTH-1];
    assign w_negateB = bSigned & dIn1[WIDTH-1];
    assign w_magIn0  = w_negateA ? w_negIn0 : dIn0;
    assign w_magIn1  = w_negateB ? w_negIn1 : dIn1;

    twos_negate #(.WIDTH(WIDTH)) u_magAdderA (.i_x(dIn0), .o_negX(w_negIn0));
    twos_negate #(.WIDTH(WIDTH)) u_magAdderB (.i_x(dIn1), .o_negX(w_negIn1));

    // Accumulate step; bit WIDTH of the sum is the carry into the shift
    assign w_addend = r_lo[0] ? {1'b0, r_magA} : '0;

    adder #(.ADDER_SIZE(WIDTH + 1)) u_accAdder (
        .i_a        (r_hi),
        .i_b        (w_addend),
        .i_cin      (1'b0),
        .o_sum      (w_sum),
        .o_overflow (w_unusedAccOvf)
    );

    adder #(.ADDER_SIZE(CNT_W)) u_cntAdder (
        .i_a        (r_cnt),
        .i_b        (c_CNT_ONE),
        .i_cin      (1'b0),
        .o_sum      (w_cntInc),
        .o_overflow (w_unusedCntOvf)
    );

    // After WIDTH steps hi[WIDTH] is always zero, so it is dropped here
    assign w_product = {r_hi[WIDTH-1:0], r_lo};

    twos_negate #(.WIDTH(2 * WIDTH)) u_negAdder (.i_x(w_product), .o_negX(w_negProduct));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = CALC;
            CALC:    if (r_cnt == c_CNT_LAST) w_nextState = FIX;
            FIX:     w_nextState = DONE;
            DONE:    w_nextState = w_accept ? CALC : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            CALC:    busy = 1'b1;
            FIX:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_magA <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_dOut <= '0;
        end else if (w_accept) begin
            r_magA <= w_magIn0;
            r_hi   <= '0;
            r_lo   <= w_magIn1;
            r_cnt  <= '0;
            r_neg  <= w_negateA ^ w_negateB;
        end else if (r_state == CALC) begin
            // {hi,lo} <= {sum,lo} >> 1
            r_hi  <= {1'b0, w_sum[WIDTH:1]};
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= w_cntInc;
        end else if (r_state == FIX) begin
            r_dOut <= r_neg ? w_negProduct : w_product;
        end
    end

    assign dOut = r_dOut;

endmodule
`default_nettype wire
